// File: rtl/alu_result_buffer.sv
// Capture buffer behind the ALU: one record per rising edge of done, kept in a
// small first-word-fall-through FIFO that drains over a valid/ready handshake.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               result,
    input  logic                     gt_zero_flag,
    input  logic                     SF,
    input  logic                     CF,
    input  logic                     ZF,
    input  logic                     done,
    output logic [9:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [CNT_W-1:0]         capture_count,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic       sf;
        logic       cf;
        logic       zf;
        logic       gt;
        logic [5:0] res;
    } rec_t;

    logic [DEPTH-1:0][9:0] mem;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_next;
    logic [LVL_W-1:0]      level_next;
    logic                  done_q;
    logic                  cap, pop, push, drop, full;
    rec_t                  rec;
    logic [9:0]            head_next;

    always_comb begin
        rec        = '{sf: SF, cf: CF, zf: ZF, gt: gt_zero_flag, res: result};
        cap        = done & ~done_q;
        pop        = out_valid & out_ready;
        full       = (level == LVL_W'(DEPTH));
        push       = cap & (~full | pop);
        drop       = cap & full & ~pop;
        rd_next    = rd_ptr + PTR_W'(pop);
        level_next = level + LVL_W'(push) - LVL_W'(pop);
        // A push landing in the slot that becomes the head must bypass the array.
        head_next  = (push && (wr_ptr == rd_next)) ? rec : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q        <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            level         <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            overflow      <= 1'b0;
            capture_count <= '0;
            drop_count    <= '0;
        end else begin
            done_q    <= done;
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_ptr + PTR_W'(push);
            level     <= level_next;
            out_valid <= (level_next != '0);
            out_data  <= (level_next != '0) ? head_next : '0;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            if (push && capture_count != '1) capture_count <= capture_count + 1'b1;
            if (drop && drop_count != '1)    drop_count    <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed and random stimulus against a queue-based model of the capture buffer.
module tb_alu_result_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  result;
    logic        gt_zero_flag, SF, CF, ZF, done;
    logic [9:0]  out_data;
    logic        out_valid, out_ready;
    logic [2:0]  level;
    logic        overflow, clr_overflow;
    logic [CNT_W-1:0] capture_count, drop_count;

    alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .result(result), .gt_zero_flag(gt_zero_flag),
        .SF(SF), .CF(CF), .ZF(ZF), .done(done), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .overflow(overflow), .clr_overflow(clr_overflow),
        .capture_count(capture_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [9:0] q[$];
    logic       m_dq;
    logic       m_ov;
    int         m_cap, m_drop;
    int         d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [31:0] head;
        head = (q.size() != 0) ? 32'(q[0]) : 32'd0;
        chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "_data"},  32'(out_data), head);
        chk({tag, "_level"}, 32'(level), 32'(q.size()));
        chk({tag, "_ovf"},   32'(overflow), 32'(m_ov));
        chk({tag, "_capc"},  32'(capture_count), 32'(m_cap));
        chk({tag, "_dropc"}, 32'(drop_count), 32'(m_drop));
    endtask

    task automatic model_reset();
        q.delete();
        m_dq = 1'b0; m_ov = 1'b0; m_cap = 0; m_drop = 0;
    endtask

    // Inputs are already set; evaluate the model against them, clock, then check.
    task automatic step(input string tag);
        logic [9:0] rec;
        logic cap, pop, full;
        rec  = {SF, CF, ZF, gt_zero_flag, result};
        cap  = done && !m_dq;
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && out_ready;
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (!full || pop) begin
                q.push_back(rec);
                if (m_cap < 255) m_cap++;
            end else begin
                if (m_drop < 255) m_drop++;
                m_ov = 1'b1;
            end
        end
        if (!(cap && full && !pop) && clr_overflow) m_ov = 1'b0;
        m_dq = done;
        @(posedge clk);
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic pulse(input logic [5:0] r, input string tag);
        result = r; done = 1'b1;
        step(tag);
        done = 1'b0;
        step(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; result = '0; gt_zero_flag = 0; SF = 0; CF = 0; ZF = 0;
        done = 0; out_ready = 0; clr_overflow = 0;
        model_reset();
        @(negedge clk);
        do_reset("rst");

        // single pulse, known record
        SF = 0; CF = 1; ZF = 0; gt_zero_flag = 1; result = 6'd21; done = 1;
        step("p1");
        chk("p1_const", 32'(out_data), 32'(10'b0101_010101));
        chk("p1_capc", 32'(capture_count), 32'd1);
        done = 0; step("p1b");
        out_ready = 1; step("drain1"); out_ready = 0;

        // done held for 5 cycles -> single capture
        result = 6'd3; done = 1;
        for (int i = 0; i < 5; i++) step("hold");
        done = 0; step("hold_end");
        chk("hold_level", 32'(level), 32'd1);
        out_ready = 1; step("drain2"); out_ready = 0;

        // six pulses into a depth-4 FIFO
        d0 = m_drop;
        for (int i = 1; i <= 6; i++) pulse(6'(i), "fill");
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_drops", 32'(drop_count), 32'(d0 + 2));
        chk("fill_ovf", 32'(overflow), 32'd1);

        // full + pop + push in the same cycle
        d0 = m_drop;
        out_ready = 1; result = 6'd9; done = 1;
        step("fpp");
        chk("fpp_level", 32'(level), 32'd4);
        chk("fpp_drop", 32'(drop_count), 32'(d0));
        done = 0;
        for (int i = 0; i < 5; i++) step("drain3");
        chk("drain3_empty", 32'(out_data), 32'd0);
        out_ready = 0;

        // drop and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) pulse(6'(i + 40), "fill2");
        result = 6'd50; done = 1; clr_overflow = 1;
        step("clr_drop");
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        done = 0; step("clr_nodrop");
        clr_overflow = 0;
        chk("clr_ovf0", 32'(overflow), 32'd0);
        out_ready = 1;
        for (int i = 0; i < 5; i++) step("drain4");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            done         = ($urandom_range(0, 2) != 0);
            out_ready    = ($urandom_range(0, 3) == 0);
            clr_overflow = ($urandom_range(0, 9) == 0);
            result       = 6'($urandom);
            {SF, CF, ZF, gt_zero_flag} = 4'($urandom);
            step("rnd");
        end
        done = 0; clr_overflow = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) step("drain5");

        // saturation of capture_count
        for (int i = 0; i < 300; i++) pulse(6'($urandom), "sat");
        chk("sat_capc", 32'(capture_count), 32'd255);

        // reset mid-stream with done high
        out_ready = 0;
        pulse(6'd7, "pre");
        result = 6'd12; done = 1;
        do_reset("rst2");
        step("post_rst");
        chk("post_rst_level", 32'(level), 32'd1);
        done = 0; step("post_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
